frame_rx_parser: RTL and testbench

Parses the raw UART receive byte stream into framed pixel data for the Canny edge pipeline, between `uart_top` (`rx_rd_data`/`rx_valid`) and `canny_edge_top` (`pixel_in`/`pixel_in_valid`).
- Hunts for a sync byte, then reads a 4-byte big-endian width/height header.
- Forwards exactly width×height pixel bytes, tagged with start-of-frame, end-of-line and end-of-frame flags.
- Aborts cleanly on a malformed header or a stalled link.

---
 rtl/definitions_pkg.sv | 23 ++
 rtl/frame_rx_parser_if.sv | 24 ++
 rtl/frame_rx_parser_timeout_cnt.sv | 27 ++
 rtl/frame_rx_parser.sv | 136 +++++++++++++
 tb/tb_frame_rx_parser.sv | 197 +++++++++++++++++++
 5 files changed

// File: rtl/definitions_pkg.sv
// Shared constants and types for the UART-to-Canny datapath.
package definitions_pkg;

   localparam int             FIFO_WIDTH        = 8;
   localparam logic [7:0]     FRAME_SYNC_BYTE   = 8'hA5;
   localparam int             MAX_FRAME_DIM     = 1024;
   localparam int             FRAME_TIMEOUT_CYC = 1_000_000;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_W_HI,
      ST_W_LO,
      ST_H_HI,
      ST_H_LO,
      ST_STREAM
   } frame_state_t;

   // Legal dimension: non-zero and within max_dim; the full 16-bit wire value is compared.
   function automatic logic dim_ok(input logic [15:0] v, input int max_dim);
      return (v != 16'd0) && (int'(v) <= max_dim);
   endfunction

endpackage

// File: rtl/frame_rx_parser_if.sv
// Byte-in / pixel-out stream bundle between the UART receiver and the edge pipeline.
interface frame_rx_parser_if
   import definitions_pkg::*;
#(
   parameter int DATA_W = FIFO_WIDTH
);
   logic [DATA_W-1:0] byte_in;
   logic              byte_in_valid;
   logic [DATA_W-1:0] pixel_out;
   logic              pixel_out_valid;
   logic              sof;
   logic              eol;
   logic              eof;

   modport master (
      output byte_in, byte_in_valid,
      input  pixel_out, pixel_out_valid, sof, eol, eof
   );

   modport slave (
      input  byte_in, byte_in_valid,
      output pixel_out, pixel_out_valid, sof, eol, eof
   );
endinterface

// File: rtl/frame_rx_parser_timeout_cnt.sv
// Saturating idle counter; expired fires on the cycle whose edge would reach TIMEOUT_CYC.
module frame_timeout_cnt
   import definitions_pkg::*;
#(
   parameter int TIMEOUT_CYC = FRAME_TIMEOUT_CYC,
   localparam int CNT_W      = $clog2(TIMEOUT_CYC + 1)
) (
   input  logic clk,
   input  logic rstN,
   input  logic clr,
   input  logic en,
   output logic expired
);
   localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT_CYC);

   logic [CNT_W-1:0] cnt;

   always_ff @(posedge clk) begin
      if (!rstN || clr)
         cnt <= '0;
      else if (en && cnt != LIMIT)
         cnt <= cnt + CNT_W'(1);
   end

   assign expired = en && !clr && (cnt == LIMIT - CNT_W'(1));

endmodule

// File: rtl/frame_rx_parser.sv
// Sync hunt, 4-byte big-endian width/height header, then width*height tagged pixels.
//
//   state     | meaning
//   ST_IDLE   | hunting for SYNC_BYTE, other bytes dropped
//   ST_W_HI   | expecting width high byte
//   ST_W_LO   | expecting width low byte
//   ST_H_HI   | expecting height high byte
//   ST_H_LO   | expecting height low byte, header checked here
//   ST_STREAM | forwarding pixels with sof/eol/eof
module frame_rx_parser
   import definitions_pkg::*;
#(
   parameter int                DATA_W      = FIFO_WIDTH,
   parameter logic [DATA_W-1:0] SYNC_BYTE   = DATA_W'(FRAME_SYNC_BYTE),
   parameter int                MAX_DIM     = MAX_FRAME_DIM,
   parameter int                DIM_W       = $clog2(MAX_DIM + 1),
   parameter int                TIMEOUT_CYC = FRAME_TIMEOUT_CYC
) (
   input  logic             clk,
   input  logic             rstN,
   frame_rx_parser_if.slave bus,
   output logic [DIM_W-1:0] frame_width,
   output logic [DIM_W-1:0] frame_height,
   output logic             busy,
   output logic             hdr_err,
   output logic             timeout
);
   frame_state_t     state;
   logic [15:0]      w_tmp;
   logic [7:0]       h_hi;
   logic [15:0]      h_full;
   logic [DIM_W-1:0] col;
   logic [DIM_W-1:0] row;
   logic             last_col;
   logic             last_row;
   logic             tmo_expired;
   logic             tmo_clr;
   logic             tmo_en;

   assign h_full   = {h_hi, bus.byte_in[7:0]};
   assign last_col = (col == frame_width - DIM_W'(1));
   assign last_row = (row == frame_height - DIM_W'(1));
   assign busy     = (state != ST_IDLE);
   assign tmo_en   = (state != ST_IDLE);
   assign tmo_clr  = bus.byte_in_valid || (state == ST_IDLE);

   frame_timeout_cnt #(
      .TIMEOUT_CYC (TIMEOUT_CYC)
   ) u_timeout_cnt (
      .clk     (clk),
      .rstN    (rstN),
      .clr     (tmo_clr),
      .en      (tmo_en),
      .expired (tmo_expired)
   );

   always_ff @(posedge clk) begin
      if (!rstN) begin
         state               <= ST_IDLE;
         w_tmp               <= '0;
         h_hi                <= '0;
         col                 <= '0;
         row                 <= '0;
         frame_width         <= '0;
         frame_height        <= '0;
         bus.pixel_out       <= '0;
         bus.pixel_out_valid <= 1'b0;
         bus.sof             <= 1'b0;
         bus.eol             <= 1'b0;
         bus.eof             <= 1'b0;
         hdr_err             <= 1'b0;
         timeout             <= 1'b0;
      end else begin
         bus.pixel_out_valid <= 1'b0;
         bus.sof             <= 1'b0;
         bus.eol             <= 1'b0;
         bus.eof             <= 1'b0;
         hdr_err             <= 1'b0;
         timeout             <= 1'b0;

         // expired already excludes a same-cycle byte, so the byte wins
         if (tmo_expired) begin
            timeout <= 1'b1;
            state   <= ST_IDLE;
         end else if (bus.byte_in_valid) begin
            case (state)
               ST_IDLE: begin
                  if (bus.byte_in == SYNC_BYTE)
                     state <= ST_W_HI;
               end
               ST_W_HI: begin
                  w_tmp[15:8] <= bus.byte_in[7:0];
                  state       <= ST_W_LO;
               end
               ST_W_LO: begin
                  w_tmp[7:0] <= bus.byte_in[7:0];
                  state      <= ST_H_HI;
               end
               ST_H_HI: begin
                  h_hi  <= bus.byte_in[7:0];
                  state <= ST_H_LO;
               end
               ST_H_LO: begin
                  if (dim_ok(w_tmp, MAX_DIM) && dim_ok(h_full, MAX_DIM)) begin
                     frame_width  <= w_tmp[DIM_W-1:0];
                     frame_height <= h_full[DIM_W-1:0];
                     col          <= '0;
                     row          <= '0;
                     state        <= ST_STREAM;
                  end else begin
                     hdr_err <= 1'b1;
                     state   <= ST_IDLE;
                  end
               end
               ST_STREAM: begin
                  bus.pixel_out       <= bus.byte_in;
                  bus.pixel_out_valid <= 1'b1;
                  bus.sof             <= (col == '0) && (row == '0);
                  bus.eol             <= last_col;
                  bus.eof             <= last_col && last_row;
                  if (last_col) begin
                     col <= '0;
                     row <= row + DIM_W'(1);
                     if (last_row)
                        state <= ST_IDLE;
                  end else begin
                     col <= col + DIM_W'(1);
                  end
               end
               default: state <= ST_IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_frame_rx_parser.sv
// Directed-vector bench for frame_rx_parser with a short timeout.
module tb_frame_rx_parser;
   import definitions_pkg::*;

   localparam int TMO = 20;

   logic        clk = 1'b0;
   logic        rstN = 1'b0;
   logic [10:0] frame_width;
   logic [10:0] frame_height;
   logic        busy;
   logic        hdr_err;
   logic        timeout;
   int          n_vec = 0;
   int          n_err = 0;

   frame_rx_parser_if #(.DATA_W(8)) bus ();

   frame_rx_parser #(
      .DATA_W      (8),
      .SYNC_BYTE   (8'hA5),
      .MAX_DIM     (1024),
      .DIM_W       (11),
      .TIMEOUT_CYC (TMO)
   ) dut (
      .clk          (clk),
      .rstN         (rstN),
      .bus          (bus.slave),
      .frame_width  (frame_width),
      .frame_height (frame_height),
      .busy         (busy),
      .hdr_err      (hdr_err),
      .timeout      (timeout)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic cyc(input logic v, input logic [7:0] b);
      bus.byte_in_valid = v;
      bus.byte_in       = b;
      @(posedge clk);
      #1;
   endtask

   task automatic out(input string tag, input logic pv, input logic s, input logic e,
                      input logic f, input logic [7:0] px, input logic bsy,
                      input logic he, input logic to);
      chk({tag, ".flags"},
          32'({busy, hdr_err, timeout, bus.pixel_out_valid, bus.sof, bus.eol, bus.eof}),
          32'({bsy, he, to, pv, s, e, f}));
      if (pv) chk({tag, ".px"}, 32'(bus.pixel_out), 32'(px));
   endtask

   task automatic pix(input string tag, input logic [7:0] b, input logic s, input logic e,
                      input logic f, input logic bsy);
      cyc(1'b1, b);
      out(tag, 1'b1, s, e, f, b, bsy, 1'b0, 1'b0);
   endtask

   task automatic hdr_body(input string tag, input logic [15:0] w, input logic [15:0] h,
                           input logic good);
      logic [7:0] bytes [4];
      bytes[0] = w[15:8];
      bytes[1] = w[7:0];
      bytes[2] = h[15:8];
      bytes[3] = h[7:0];
      for (int i = 0; i < 3; i++) begin
         cyc(1'b1, bytes[i]);
         out(tag, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
      end
      cyc(1'b1, bytes[3]);
      out({tag, ".last"}, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, good, !good, 1'b0);
   endtask

   task automatic hdr(input string tag, input logic [15:0] w, input logic [15:0] h,
                      input logic good);
      cyc(1'b1, 8'hA5);
      out({tag, ".sync"}, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
      hdr_body(tag, w, h, good);
   endtask

   initial begin
      bus.byte_in       = 8'h00;
      bus.byte_in_valid = 1'b0;

      // reset
      cyc(1'b0, 8'h00);
      cyc(1'b1, 8'hA5);
      out("rst", 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
      chk("rst.px", 32'(bus.pixel_out), 32'h0);
      chk("rst.dims", 32'({frame_width, frame_height}), 32'h0);
      rstN = 1'b1;

      // 4x2 frame
      hdr("f42", 16'd4, 16'd2, 1'b1);
      pix("f42.p0", 8'h10, 1, 0, 0, 1);
      pix("f42.p1", 8'h11, 0, 0, 0, 1);
      pix("f42.p2", 8'h12, 0, 0, 0, 1);
      pix("f42.p3", 8'h13, 0, 1, 0, 1);
      pix("f42.p4", 8'h14, 0, 0, 0, 1);
      pix("f42.p5", 8'h15, 0, 0, 0, 1);
      pix("f42.p6", 8'h16, 0, 0, 0, 1);
      pix("f42.p7", 8'h17, 0, 1, 1, 0);
      chk("f42.w", 32'(frame_width), 32'd4);
      chk("f42.h", 32'(frame_height), 32'd2);
      cyc(1'b0, 8'h00);
      out("f42.after", 0, 0, 0, 0, 8'h00, 0, 0, 0);
      chk("f42.hold", 32'(bus.pixel_out), 32'h17);

      // noise, zero-width header, then 1x1
      cyc(1'b1, 8'h00); out("noise0", 0, 0, 0, 0, 8'h00, 0, 0, 0);
      cyc(1'b1, 8'hFF); out("noise1", 0, 0, 0, 0, 8'h00, 0, 0, 0);
      cyc(1'b1, 8'h5A); out("noise2", 0, 0, 0, 0, 8'h00, 0, 0, 0);
      hdr("w0", 16'd0, 16'd3, 1'b0);
      cyc(1'b0, 8'h00);
      out("w0.pulse", 0, 0, 0, 0, 8'h00, 0, 0, 0);
      chk("w0.keepw", 32'(frame_width), 32'd4);
      hdr("f11", 16'd1, 16'd1, 1'b1);
      pix("f11.p0", 8'h42, 1, 1, 1, 0);

      // oversize width, then sync re-enters header
      hdr("w1025", 16'd1025, 16'd1, 1'b0);
      chk("w1025.keeph", 32'(frame_height), 32'd1);
      cyc(1'b1, 8'hA5);
      out("resync", 0, 0, 0, 0, 8'h00, 1, 0, 0);
      hdr_body("t22", 16'd2, 16'd2, 1'b1);

      // timeout after 3 of 4 pixels
      pix("t22.p0", 8'h11, 1, 0, 0, 1);
      pix("t22.p1", 8'h12, 0, 1, 0, 1);
      pix("t22.p2", 8'h13, 0, 0, 0, 1);
      for (int i = 0; i < TMO - 1; i++) begin
         cyc(1'b0, 8'h00);
         out("t22.wait", 0, 0, 0, 0, 8'h00, 1, 0, 0);
      end
      cyc(1'b0, 8'h00);
      out("t22.tmo", 0, 0, 0, 0, 8'h00, 0, 0, 1);
      cyc(1'b0, 8'h00);
      out("t22.tmo_end", 0, 0, 0, 0, 8'h00, 0, 0, 0);

      // byte on expiry cycle keeps the frame alive
      hdr("a22", 16'd2, 16'd2, 1'b1);
      pix("a22.p0", 8'h21, 1, 0, 0, 1);
      pix("a22.p1", 8'h22, 0, 1, 0, 1);
      pix("a22.p2", 8'h23, 0, 0, 0, 1);
      for (int i = 0; i < TMO - 1; i++) begin
         cyc(1'b0, 8'h00);
         out("a22.wait", 0, 0, 0, 0, 8'h00, 1, 0, 0);
      end
      pix("a22.p3", 8'h24, 0, 1, 1, 0);
      cyc(1'b0, 8'h00);
      out("a22.after", 0, 0, 0, 0, 8'h00, 0, 0, 0);

      // two back-to-back 2x2 frames, A5 as pixel data
      hdr("b1", 16'd2, 16'd2, 1'b1);
      pix("b1.p0", 8'h31, 1, 0, 0, 1);
      pix("b1.p1", 8'hA5, 0, 1, 0, 1);
      pix("b1.p2", 8'h33, 0, 0, 0, 1);
      pix("b1.p3", 8'h34, 0, 1, 1, 0);
      hdr("b2", 16'd2, 16'd2, 1'b1);
      pix("b2.p0", 8'h41, 1, 0, 0, 1);
      pix("b2.p1", 8'h42, 0, 1, 0, 1);
      pix("b2.p2", 8'h43, 0, 0, 0, 1);
      pix("b2.p3", 8'h44, 0, 1, 1, 0);

      // reset mid-frame
      hdr("r44", 16'd4, 16'd4, 1'b1);
      pix("r44.p0", 8'h50, 1, 0, 0, 1);
      pix("r44.p1", 8'h51, 0, 0, 0, 1);
      pix("r44.p2", 8'h52, 0, 0, 0, 1);
      rstN = 1'b0;
      cyc(1'b1, 8'h53);
      out("r44.rst", 0, 0, 0, 0, 8'h00, 0, 0, 0);
      chk("r44.rst_px", 32'(bus.pixel_out), 32'h0);
      chk("r44.rst_dims", 32'({frame_width, frame_height}), 32'h0);
      rstN = 1'b1;
      for (int i = 0; i < 12; i++) begin
         cyc(1'b1, 8'(8'h54 + i));
         out("r44.drop", 0, 0, 0, 0, 8'h00, 0, 0, 0);
      end
      hdr("r11", 16'd1, 16'd1, 1'b1);
      pix("r11.p0", 8'h77, 1, 1, 1, 0);
      chk("r11.w", 32'(frame_width), 32'd1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
